// File: rtl/tx_serializer_pkg.sv
// tx_serializer_pkg: shared TX types and defaults (state enum, default word width, idle line level)
package tx_serializer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tx_state_e;
  localparam int TX_DATA_WIDTH = 10;
  localparam logic TX_IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/tx_word_clk_gen.sv
// tx_word_clk_gen: bit counter with word-boundary strobe and registered divide-by-DATA_WIDTH Word_Clk; ports CLK, RST (async low), Run, Boundary, Word_Clk
module tx_word_clk_gen
  import tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH
) (
  input  logic CLK,
  input  logic RST,
  input  logic Run,
  output logic Boundary,
  output logic Word_Clk
);
  localparam int CW = $clog2(DATA_WIDTH);
  logic [CW-1:0] bit_cnt;
  assign Boundary = Run && (bit_cnt == CW'(DATA_WIDTH - 1));
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      bit_cnt  <= '0;
      Word_Clk <= 1'b0;
    end else begin
      bit_cnt  <= (Run && !Boundary) ? bit_cnt + 1'b1 : '0;
      Word_Clk <= Run && (bit_cnt < CW'(DATA_WIDTH / 2));
    end
endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: double-buffered LSB-first parallel-to-serial stage; ports CLK, RST (async low), Tx_En, Data_In/Data_Valid/Data_Ready, Serial_Out, Word_Clk, Busy, Underflow
module tx_serializer
  import tx_serializer_pkg::*;
#(
  parameter int   DATA_WIDTH = TX_DATA_WIDTH,
  parameter logic IDLE_LEVEL = TX_IDLE_LEVEL
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Tx_En,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  output logic                  Serial_Out,
  output logic                  Word_Clk,
  output logic                  Busy,
  output logic                  Underflow
);
  tx_state_e state, state_nxt;
  logic [DATA_WIDTH-1:0] hold_reg, shift_reg;
  logic hold_full, boundary, accept, load;
  tx_word_clk_gen #(.DATA_WIDTH(DATA_WIDTH)) u_word_clk (
    .CLK     (CLK),
    .RST     (RST),
    .Run     (Busy),
    .Boundary(boundary),
    .Word_Clk(Word_Clk)
  );
  assign Data_Ready = !hold_full;
  assign Busy = (state == RUN);
  always_comb begin
    accept    = Data_Valid && !hold_full;
    load      = Tx_En && hold_full && (state == IDLE || boundary);
    state_nxt = load ? RUN : boundary ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      Serial_Out <= IDLE_LEVEL;
      Underflow  <= 1'b0;
    end else begin
      if (accept) hold_reg <= Data_In;
      hold_full  <= load ? 1'b0 : (accept || hold_full);
      shift_reg  <= load ? hold_reg : Busy ? shift_reg >> 1 : shift_reg;
      Serial_Out <= Busy ? shift_reg[0] : IDLE_LEVEL;
      Underflow  <= boundary && Tx_En && !hold_full;
    end
endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: directed self-checking bench for tx_serializer (10-bit and 7-bit builds)
module tb_tx_serializer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic tx_en, valid, tx_en7, valid7;
  logic [9:0] data;
  logic [6:0] data7;
  logic ready, sout, wclk, busy, uflow;
  logic ready7, sout7, wclk7, busy7, uflow7;
  logic [19:0] stream;
  logic [9:0] w;
  logic [6:0] w7;
  int n_checks = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  tx_serializer dut (
    .CLK(CLK), .RST(RST), .Tx_En(tx_en), .Data_In(data), .Data_Valid(valid),
    .Data_Ready(ready), .Serial_Out(sout), .Word_Clk(wclk), .Busy(busy), .Underflow(uflow)
  );
  tx_serializer #(.DATA_WIDTH(7)) dut7 (
    .CLK(CLK), .RST(RST), .Tx_En(tx_en7), .Data_In(data7), .Data_Valid(valid7),
    .Data_Ready(ready7), .Serial_Out(sout7), .Word_Clk(wclk7), .Busy(busy7), .Underflow(uflow7)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    tx_en = 0; valid = 0; data = '0;
    tx_en7 = 0; valid7 = 0; data7 = '0;
    #12;
    chk("reset_ready", ready, 1);
    chk("reset_sout", sout, 0);
    chk("reset_wclk", wclk, 0);
    chk("reset_busy", busy, 0);
    chk("reset_uflow", uflow, 0);
    tick(); tick();
    RST = 1;
    tick();
    // reset in the middle of word 2AA with a second word buffered
    tx_en = 1; data = 10'h2AA; valid = 1;
    tick();
    data = 10'h3FF;
    tick();
    tick();
    valid = 0;
    tick(); tick(); tick();
    chk("rst_bit3_sout", sout, 1);
    tick();
    chk("rst_bit4_busy", busy, 1);
    chk("rst_bit4_ready", ready, 0);
    chk("rst_bit4_wclk", wclk, 1);
    RST = 0;
    #1;
    chk("rst_async_sout", sout, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", ready, 1);
    chk("rst_async_wclk", wclk, 0);
    #2;
    RST = 1;
    tick(); tick(); tick();
    chk("rst_discard_busy", busy, 0);
    chk("rst_discard_sout", sout, 0);
    chk("rst_discard_ready", ready, 1);
    // single word followed by underflow
    data = 10'h3A5; valid = 1;
    tick();
    valid = 0;
    chk("single_ready_low", ready, 0);
    tick();
    chk("single_busy", busy, 1);
    chk("single_idle_level", sout, 0);
    tick();
    w = 10'h3A5;
    for (int i = 0; i < 10; i++) begin
      chk("single_sout", sout, w[i]);
      chk("single_wclk", wclk, i < 5);
      chk("single_busy_run", busy, i < 9);
      chk("single_uflow", uflow, i == 9);
      tick();
    end
    chk("single_uflow_end", uflow, 0);
    chk("single_busy_end", busy, 0);
    chk("single_sout_end", sout, 0);
    chk("single_wclk_end", wclk, 0);
    // back-to-back words with Data_Valid held high
    data = 10'h155; valid = 1;
    tick();
    data = 10'h0F0;
    chk("b2b_ready_after_accept", ready, 0);
    tick();
    chk("b2b_ready_reopen", ready, 1);
    tick();
    valid = 0;
    stream = {10'h0F0, 10'h155};
    for (int i = 0; i < 20; i++) begin
      chk("b2b_sout", sout, stream[i]);
      chk("b2b_uflow", uflow, i == 19);
      chk("b2b_ready", ready, i >= 9);
      chk("b2b_busy", busy, i < 19);
      chk("b2b_wclk", wclk, (i % 10) < 5);
      tick();
    end
    // backpressure: later Data_In values must be ignored
    tx_en = 0; data = 10'h1C3; valid = 1;
    tick();
    data = 10'h23C;
    chk("bp_ready", ready, 0);
    tick();
    data = 10'h3FF;
    tick();
    chk("bp_ready_hold", ready, 0);
    chk("bp_busy_idle", busy, 0);
    valid = 0; tx_en = 1;
    tick();
    tick();
    w = 10'h1C3;
    for (int i = 0; i < 10; i++) begin
      chk("bp_sout", sout, w[i]);
      tick();
    end
    // Tx_En dropped mid-word with a second word buffered
    data = 10'h3FF; valid = 1;
    tick();
    data = 10'h0A5;
    tick();
    tick();
    valid = 0;
    for (int i = 0; i < 10; i++) begin
      chk("drop_sout", sout, 1);
      chk("drop_uflow", uflow, 0);
      chk("drop_ready", ready, 0);
      chk("drop_busy", busy, i < 9);
      if (i == 3) tx_en = 0;
      tick();
    end
    tick(); tick();
    chk("drop_idle_busy", busy, 0);
    chk("drop_idle_sout", sout, 0);
    chk("drop_hold_kept", ready, 0);
    chk("drop_idle_uflow", uflow, 0);
    tx_en = 1;
    tick();
    chk("drop_resume_busy", busy, 1);
    tick();
    w = 10'h0A5;
    for (int i = 0; i < 10; i++) begin
      chk("drop_resume_sout", sout, w[i]);
      chk("drop_resume_uflow", uflow, i == 9);
      tick();
    end
    // 7-bit build
    tx_en7 = 1; data7 = 7'h5A; valid7 = 1;
    tick();
    valid7 = 0;
    chk("w7_ready_low", ready7, 0);
    tick();
    tick();
    w7 = 7'h5A;
    for (int i = 0; i < 7; i++) begin
      chk("w7_sout", sout7, w7[i]);
      chk("w7_wclk", wclk7, i < 3);
      chk("w7_busy", busy7, i < 6);
      chk("w7_uflow", uflow7, i == 6);
      tick();
    end
    chk("w7_busy_end", busy7, 0);
    chk("w7_sout_end", sout7, 0);
    chk("w7_ready_end", ready7, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
